// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration-time helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_ADDR_WIDTH = 3;

  // Thresholds must fall inside the reachable occupancy range to be meaningful.
  function automatic bit thresh_legal(input int af, input int ae, input int depth);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage: one write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy counter, flag decode and sticky errors
// around a fifo_mem storage array.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] Fifo_Data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error_overflow,
  output logic                  error_underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_THRESH[ADDR_WIDTH:0];

  generate
    if (!thresh_legal(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
      $error("sync_fifo: AF_THRESH/AE_THRESH outside legal range");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  valid_q;
  logic                  pop_ok_s, push_ok_s;
  logic                  full_s, empty_s;

  assign full_s  = (count_q == DEPTH_CNT);
  assign empty_s = (count_q == {(ADDR_WIDTH+1){1'b0}});

  // A push into a full FIFO is legal only when a pop frees a slot on the same edge.
  always_comb begin
    pop_ok_s  = read_enable && !empty_s;
    push_ok_s = write_enable && (!full_s || pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    if (write_enable && !push_ok_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (read_enable && !pop_ok_s) begin
      unf_d = 1'b1;
    end else begin
      unf_d = unf_q;
    end
  end

  // Control state; reset wins over any request on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q <= {ADDR_WIDTH{1'b0}};
      count_q  <= {(ADDR_WIDTH+1){1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= pop_ok_s;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push_ok_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (Fifo_Data_in),
    .re_i    (pop_ok_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (Fifo_Data_out)
  );

  assign data_valid      = valid_q;
  assign full            = full_s;
  assign empty           = empty_s;
  assign almost_full     = (count_q >= AF_CNT);
  assign almost_empty    = (count_q <= AE_CNT);
  assign count           = count_q;
  assign error_overflow  = ovf_q;
  assign error_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 12;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          we, re;
  logic [DW-1:0] dout;
  logic          dvalid, full, empty, afull, aempty, ovf, unf;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_out;
  bit            m_valid, m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .Fifo_Data_in(din), .write_enable(we), .read_enable(re),
    .Fifo_Data_out(dout), .data_valid(dvalid), .full(full), .empty(empty),
    .almost_full(afull), .almost_empty(aempty), .count(count),
    .error_overflow(ovf), .error_underflow(unf)
  );

  // one clock: drive inputs, advance model at the edge, return at the falling edge
  task automatic cycle(input logic w, input logic r, input logic rst, input logic [DW-1:0] d);
    bit pop, push;
    we = w; re = r; reset = rst; din = d;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_out = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
    end else begin
      pop  = r && (mq.size() != 0);
      push = w && ((mq.size() < DEPTH) || pop);
      m_valid = pop;
      if (pop) m_out = mq.pop_front();
      if (push) mq.push_back(d);
      if (w && !push) m_ovf = 1;
      if (r && !pop) m_unf = 1;
    end
    @(negedge clk);
  endtask

  function automatic logic [22:0] model_vec();
    int sz = mq.size();
    return {4'(sz), 1'(sz == DEPTH), 1'(sz == 0), 1'(sz >= AF), 1'(sz <= AE),
            m_valid, m_ovf, m_unf, m_out};
  endfunction

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b1, 12'h000);
    cycle(1'b0, 1'b0, 1'b1, 12'h000);
    n_cmp++;
    if ({count, empty, aempty, full, afull} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b", count, empty, aempty, full, afull);
    end
    n_cmp++;
    if ({dout, dvalid, ovf, unf} !== {12'h000, 3'b000}) begin
      n_err++; $display("FAIL reset_out: got dout=%h v=%b ovf=%b unf=%b, want 000/0/0/0", dout, dvalid, ovf, unf);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 12'(i));
      n_cmp++;
      if ({count, afull, full, ovf, unf} !== {4'(i), 1'(i >= 6), 1'(i == 8), 2'b00}) begin
        n_err++; $display("FAIL fill[%0d]: got cnt=%0d af=%b f=%b ovf=%b unf=%b", i, count, afull, full, ovf, unf);
      end
    end
  endtask

  task automatic test_overflow_drain();
    cycle(1'b1, 1'b0, 1'b0, 12'hABC);
    n_cmp++;
    if ({ovf, count} !== {1'b1, 4'd8}) begin
      n_err++; $display("FAIL overflow: got ovf=%b cnt=%0d, want 1/8", ovf, count);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 12'h000);
      n_cmp++;
      if ({dvalid, dout} !== {1'b1, 12'(i)}) begin
        n_err++; $display("FAIL drain[%0d]: got v=%b dout=%h, want 1/%h", i, dvalid, dout, 12'(i));
      end
    end
    n_cmp++;
    if ({empty, count} !== {1'b1, 4'd0}) begin
      n_err++; $display("FAIL drain_empty: got e=%b cnt=%0d", empty, count);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b1, 1'b0, 12'h000);
    n_cmp++;
    if ({unf, dvalid, dout, count} !== {1'b1, 1'b0, 12'h008, 4'd0}) begin
      n_err++; $display("FAIL underflow: got unf=%b v=%b dout=%h cnt=%0d, want 1/0/008/0", unf, dvalid, dout, count);
    end
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] oldest;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 12'($urandom));
    oldest = mq[0];
    cycle(1'b1, 1'b1, 1'b0, 12'h0F0);
    n_cmp++;
    if ({dvalid, dout, count} !== {1'b1, oldest, 4'd8}) begin
      n_err++; $display("FAIL full_pushpop: got v=%b dout=%h cnt=%0d, want 1/%h/8", dvalid, dout, count, oldest);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 12'h000);
      n_cmp++;
      if (model_vec() !== {count, full, empty, afull, aempty, dvalid, ovf, unf, dout}) begin
        n_err++; $display("FAIL full_pushpop_drain[%0d]: got dout=%h cnt=%0d, want dout=%h cnt=%0d", i, dout, count, m_out, mq.size());
      end
    end
    n_cmp++;
    if (dout !== 12'h0F0) begin
      n_err++; $display("FAIL full_pushpop_last: got %h, want 0f0", dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[20];
    int rx = 0;
    cycle(1'b0, 1'b0, 1'b1, 12'h000);
    for (int i = 0; i < 20; i++) words[i] = 12'($urandom);
    for (int i = 0; i <= 20; i++) begin
      cycle(i < 20, i > 0, 1'b0, (i < 20) ? words[i] : 12'h000);
      n_cmp++;
      if (count > 4'd1) begin
        n_err++; $display("FAIL stream_count[%0d]: got %0d, want <=1", i, count);
      end
      if (i > 0) begin
        n_cmp++;
        if ({dvalid, dout} !== {1'b1, words[rx]}) begin
          n_err++; $display("FAIL stream_data[%0d]: got v=%b %h, want 1/%h", rx, dvalid, dout, words[rx]);
        end
        rx++;
      end
    end
    n_cmp++;
    if ({empty, ovf, unf} !== 3'b100) begin
      n_err++; $display("FAIL stream_end: got e=%b ovf=%b unf=%b, want 1/0/0", empty, ovf, unf);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 12'($urandom));
    cycle(1'b0, 1'b1, 1'b0, 12'h000);
    cycle(1'b1, 1'b1, 1'b0, 12'h123);
    cycle(1'b1, 1'b0, 1'b0, 12'h456);
    cycle(1'b0, 1'b1, 1'b0, 12'h000);
    cycle(1'b1, 1'b0, 1'b0, 12'h789);
    n_cmp++;
    if (count !== 4'd5) begin
      n_err++; $display("FAIL reset_mid_pre: got cnt=%0d, want 5", count);
    end
    cycle(1'b1, 1'b0, 1'b1, 12'hFFF);
    n_cmp++;
    if ({count, empty, ovf, unf, dout, dvalid} !== {4'd0, 1'b1, 2'b00, 12'h000, 1'b0}) begin
      n_err++; $display("FAIL reset_mid: got cnt=%0d e=%b ovf=%b unf=%b dout=%h v=%b", count, empty, ovf, unf, dout, dvalid);
    end
    cycle(1'b0, 1'b0, 1'b0, 12'h000);
    n_cmp++;
    if ({count, empty} !== {4'd0, 1'b1}) begin
      n_err++; $display("FAIL reset_mid_discard: got cnt=%0d e=%b, want 0/1", count, empty);
    end
  endtask

  task automatic test_random();
    int wp, rp;
    for (int blk = 0; blk < 6; blk++) begin
      wp = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 30 : 55;
      rp = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 80 : 55;
      for (int i = 0; i < 60; i++) begin
        cycle($urandom_range(99) < wp, $urandom_range(99) < rp,
              $urandom_range(99) == 0, 12'($urandom));
        n_cmp++;
        if (model_vec() !== {count, full, empty, afull, aempty, dvalid, ovf, unf, dout}) begin
          n_err++;
          $display("FAIL random[%0d.%0d]: got {cnt,f,e,af,ae,v,ovf,unf,dout}=%h, want %h",
                   blk, i, {count, full, empty, afull, aempty, dvalid, ovf, unf, dout}, model_vec());
        end
      end
    end
  endtask

  initial begin
    we = 1'b0; re = 1'b0; reset = 1'b1; din = '0;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_full_pushpop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
